sprite_frame_counter: RTL and testbench

Synthesisable per-frame pixel statistics unit for the Genius VGA renderer. It counts, for each of N_CH sprite-enable lines, the active-video pixels during which that line is high, over one full frame bounded by VGA_VS rising edges. Results are latched and read back via a select port. It sits beside the sprite compositor on the pixel-clock domain as a hardware self-check and a debug tap.

---
 rtl/sprite_frame_counter_if.sv | 35 +++
 rtl/sprite_frame_counter.sv | 152 +++++++++++++++
 tb/tb_sprite_frame_counter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_frame_counter_if.sv
// Bus bundle for sprite_frame_counter: video taps, control and readback.
// SPRITE_COLLISION_EN widens OVF by one bit for the collision channel.
interface sprite_frame_counter_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 19,
  parameter int SEL_W = 4
);
`ifdef SPRITE_COLLISION_EN
  localparam int OVF_W = N_CH + 1;
`else
  localparam int OVF_W = N_CH;
`endif

  logic [N_CH-1:0]  SPRITES_EN;
  logic             VGA_BLANK_N;
  logic             VGA_VS;
  logic             START;
  logic             CONT;
  logic [SEL_W-1:0] RD_SEL;
  logic [CNT_W-1:0] RD_DATA;
  logic [OVF_W-1:0] OVF;
  logic             FRAME_DONE;
  logic [7:0]       FRAME_CNT;
  logic             BUSY;

  modport master (
    output SPRITES_EN, VGA_BLANK_N, VGA_VS, START, CONT, RD_SEL,
    input  RD_DATA, OVF, FRAME_DONE, FRAME_CNT, BUSY
  );

  modport slave (
    input  SPRITES_EN, VGA_BLANK_N, VGA_VS, START, CONT, RD_SEL,
    output RD_DATA, OVF, FRAME_DONE, FRAME_CNT, BUSY
  );
endinterface

// File: rtl/sprite_frame_counter.sv
// Per-frame active-pixel counter for each sprite-enable line, frames bounded
// by VGA_VS rising edges; results latched and read back through RD_SEL.
// Optional macro SPRITE_COLLISION_EN adds a channel at index N_CH counting
// active pixels with two or more sprites enabled.

// One saturating accumulator with a sticky overflow flag.
module sfc_lane #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] acc_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  // clear wins; an increment at full scale holds the value and flags overflow
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&acc_q) ovf_d = 1'b1;
      else        acc_d = acc_q + 1'b1;
    end
  end

  // accumulator state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

module sprite_frame_counter #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 19,
  parameter int SEL_W = 4
) (
  input  logic CLOCK_25,
  input  logic RESET,
  sprite_frame_counter_if.slave bus
);
`ifdef SPRITE_COLLISION_EN
  localparam int NACC = N_CH + 1;
`else
  localparam int NACC = N_CH;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic                       vs_q;
  logic                       vs_rise;
  logic                       clr, cnt_en, capture;
  logic [NACC-1:0]            hit;
  logic [NACC-1:0][CNT_W-1:0] acc;
  logic [NACC-1:0]            lovf;
  logic [NACC-1:0][CNT_W-1:0] res_q;
  logic [NACC-1:0]            ovf_q;
  logic                       done_q;
  logic [7:0]                 fcnt_q;
  logic [CNT_W-1:0]           rd_q, rd_d;

  assign vs_rise = bus.VGA_VS & ~vs_q;
  // the vs_rise pixel is never counted; accumulators restart on every boundary
  assign clr     = (state_q == S_IDLE) | vs_rise;
  assign cnt_en  = (state_q == S_COUNT) & ~vs_rise & bus.VGA_BLANK_N;
  assign capture = (state_q == S_COUNT) & vs_rise;

  // per-channel hit for this pixel (plus the overlap channel when enabled)
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) hit[i] = bus.SPRITES_EN[i];
`ifdef SPRITE_COLLISION_EN
    hit[N_CH] = ($countones(bus.SPRITES_EN) >= 2);
`endif
  end

  for (genvar g = 0; g < NACC; g++) begin : g_lane
    sfc_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (CLOCK_25),
      .rst   (RESET),
      .clr_i (clr),
      .inc_i (cnt_en & hit[g]),
      .acc_o (acc[g]),
      .ovf_o (lovf[g])
    );
  end

  // arm on START, start counting at the next boundary, capture at the one after
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.START) state_d = S_WAIT;
      S_WAIT:  if (vs_rise)   state_d = S_COUNT;
      S_COUNT: if (vs_rise)   state_d = bus.CONT ? S_COUNT : S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // readback mux; selects with no backing register read as zero
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NACC; i++)
      if (bus.RD_SEL == SEL_W'(i)) rd_d = res_q[i];
  end

  // FSM, sync edge detector, latched results and readback register
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b1;
      res_q   <= '0;
      ovf_q   <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= bus.VGA_VS;
      done_q  <= capture;
      rd_q    <= rd_d;
      if (capture) begin
        res_q  <= acc;
        ovf_q  <= lovf;
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  assign bus.RD_DATA    = rd_q;
  assign bus.OVF        = ovf_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.FRAME_CNT  = fcnt_q;
  assign bus.BUSY       = (state_q != S_IDLE);
endmodule

// File: tb/tb_sprite_frame_counter.sv
// Randomized scoreboard bench for sprite_frame_counter (small CNT_W so that
// saturation is reachable in short synthetic frames).
module tb_sprite_frame_counter;
  localparam int N_CH  = 8;
  localparam int CNT_W = 6;
  localparam int SEL_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;
`ifdef SPRITE_COLLISION_EN
  localparam int NACC = N_CH + 1;
`else
  localparam int NACC = N_CH;
`endif

  logic CLOCK_25 = 1'b0;
  logic RESET;
  always #5 CLOCK_25 = ~CLOCK_25;

  sprite_frame_counter_if #(.N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  sprite_frame_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .CLOCK_25 (CLOCK_25),
    .RESET    (RESET),
    .bus      (bus)
  );

  typedef struct {
    int              fcnt;
    logic [NACC-1:0] ovf;
  } done_t;

  done_t doneq[$];
  int    rdq[$];
  int    ncmp = 0;
  int    nerr = 0;

  // reference model: raw per-frame pixel counts, saturation applied at capture
  int mst;            // 0 idle, 1 armed, 2 counting
  int cnt [NACC];
  int mres[NACC];
  int mfcnt;
  bit mprev;
  bit rd_req = 0, rd_req_d = 0;
  bit rnd_start = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mst = 0; mprev = 1; mfcnt = 0;
    for (int i = 0; i < NACC; i++) begin cnt[i] = 0; mres[i] = 0; end
  endtask

  // evaluate what the coming clock edge does, then advance one cycle
  task automatic step();
    done_t d;
    bit    rise;
    int    s;
    if (rd_req) begin
      s = int'(bus.RD_SEL);
      rdq.push_back((s < NACC) ? mres[s] : 0);
    end
    rise = bus.VGA_VS && !mprev;
    case (mst)
      0: if (bus.START) mst = 1;
      1: if (rise) begin
           mst = 2;
           for (int i = 0; i < NACC; i++) cnt[i] = 0;
         end
      default: if (rise) begin
           mfcnt  = (mfcnt + 1) % 256;
           d.fcnt = mfcnt;
           for (int i = 0; i < NACC; i++) begin
             mres[i]  = (cnt[i] > MAXV) ? MAXV : cnt[i];
             d.ovf[i] = (cnt[i] > MAXV);
             cnt[i]   = 0;
           end
           doneq.push_back(d);
           if (!bus.CONT) mst = 0;
         end else if (bus.VGA_BLANK_N) begin
           for (int i = 0; i < N_CH; i++) if (bus.SPRITES_EN[i]) cnt[i]++;
`ifdef SPRITE_COLLISION_EN
           if ($countones(bus.SPRITES_EN) >= 2) cnt[N_CH]++;
`endif
         end
    endcase
    mprev = bus.VGA_VS;
    @(posedge CLOCK_25); #1;
  endtask

  task automatic rdsweep();
    for (int s = 0; s < NACC + 2; s++) begin
      bus.RD_SEL = (s == NACC + 1) ? {SEL_W{1'b1}} : SEL_W'(s);
      rd_req = 1;
      step();
    end
    rd_req = 0;
    step();
  endtask

  // sync (with readback), boundary, back porch, then nact active-region cycles
  task automatic frame(input int nact, input logic [N_CH-1:0] mask, input bit dense);
    bus.VGA_VS = 0; bus.VGA_BLANK_N = 0;
    repeat (2) begin bus.SPRITES_EN = N_CH'($urandom); step(); end
    rdsweep();
    bus.VGA_VS = 1;
    repeat (3) begin bus.SPRITES_EN = N_CH'($urandom); step(); end
    for (int p = 0; p < nact; p++) begin
      bus.VGA_BLANK_N = ($urandom % 4) != 0;
      bus.SPRITES_EN  = dense ? mask : (N_CH'($urandom) & mask);
      bus.START       = rnd_start && ($urandom % 16 == 0);
      step();
    end
    bus.VGA_BLANK_N = 0; bus.START = 0;
  endtask

  always @(posedge CLOCK_25) rd_req_d <= rd_req;

  // monitor: compare every captured result set and every readback
  done_t md;
  always @(negedge CLOCK_25) begin
    if (!RESET) begin
      if (bus.FRAME_DONE) begin
        if (doneq.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL frame_done: unexpected pulse, fcnt=%0d (t=%0t)", bus.FRAME_CNT, $time);
        end else begin
          md = doneq.pop_front();
          chk("frame_cnt", int'(bus.FRAME_CNT), md.fcnt);
          chk("ovf", int'(bus.OVF), int'(md.ovf));
        end
      end
      if (rd_req_d) begin
        if (rdq.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL rd_data: no expected entry, got %0d", bus.RD_DATA);
        end else begin
          chk("rd_data", int'(bus.RD_DATA), rdq.pop_front());
        end
      end
    end
  end

  initial begin
    RESET = 1;
    bus.SPRITES_EN = '0; bus.VGA_BLANK_N = 0; bus.VGA_VS = 1;
    bus.START = 0; bus.CONT = 0; bus.RD_SEL = '0;
    model_reset();
    repeat (3) @(posedge CLOCK_25);
    #1 RESET = 0;
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_fcnt", int'(bus.FRAME_CNT), 0);
    chk("rst_ovf", int'(bus.OVF), 0);
    chk("rst_done", int'(bus.FRAME_DONE), 0);
    chk("rst_rd", int'(bus.RD_DATA), 0);

    // idle: frames go by without START
    frame(60, '1, 1);
    frame(60, '1, 0);
    rdsweep();
    chk("idle_busy", int'(bus.BUSY), 0);
    chk("idle_fcnt", int'(bus.FRAME_CNT), 0);

    // single shot
    bus.START = 1; step(); bus.START = 0;
    chk("arm_busy", int'(bus.BUSY), 1);
    frame(80, 8'h09, 0);
    frame(40, '1, 0);
    rdsweep();
    chk("shot_busy", int'(bus.BUSY), 0);

    // saturation on channel 2
    bus.START = 1; step(); bus.START = 0;
    frame(120, 8'h04, 1);
    frame(10, '1, 0);
    rdsweep();

    // continuous mode, then drop CONT mid-frame
    bus.CONT = 1;
    bus.START = 1; step(); bus.START = 0;
    for (int k = 1; k <= 4; k++) frame(10 * k + 20, N_CH'($urandom), 0);
    chk("cont_busy", int'(bus.BUSY), 1);
    bus.CONT = 0;
    frame(50, '1, 0);
    frame(20, '1, 0);
    rdsweep();
    chk("cont_end_busy", int'(bus.BUSY), 0);

    // randomized: random CONT, stray STARTs during active video
    rnd_start = 1;
    for (int r = 0; r < 6; r++) begin
      bus.CONT = $urandom % 2;
      frame($urandom_range(20, 110), N_CH'($urandom), $urandom % 3 == 0);
    end
    bus.CONT = 0;
    rnd_start = 0;
    frame(10, '1, 0);
    frame(10, '1, 0);
    rdsweep();

    // reset in the middle of a counted frame
    bus.START = 1; step(); bus.START = 0;
    frame(50, '1, 0);
    bus.VGA_BLANK_N = 1;
    repeat (10) begin bus.SPRITES_EN = N_CH'($urandom); step(); end
    RESET = 1;
    model_reset();
    repeat (2) @(posedge CLOCK_25);
    #1 RESET = 0;
    bus.VGA_BLANK_N = 0;
    chk("mrst_fcnt", int'(bus.FRAME_CNT), 0);
    chk("mrst_ovf", int'(bus.OVF), 0);
    chk("mrst_busy", int'(bus.BUSY), 0);
    chk("mrst_rd", int'(bus.RD_DATA), 0);
    repeat (4) step();
    rdsweep();
    frame(30, '1, 0);
    rdsweep();

    repeat (3) step();
    chk("done_queue_empty", doneq.size(), 0);
    chk("rd_queue_empty", rdq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
